// File: rtl/hyper_pkg.sv
// Shared types and helpers for the HyperBus transaction sequencer:
// FSM state encoding, command/address word layout and burst length clamping.
package hyper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_DATA,
    ST_DONE
  } hyper_state_e;

  localparam int unsigned CA_W         = 48;
  localparam int unsigned CA_RW_BIT    = 47;
  localparam int unsigned CA_AS_BIT    = 46;
  localparam int unsigned CA_BURST_BIT = 45;
  localparam int unsigned CA_ROW_HI    = 44;
  localparam int unsigned CA_ROW_LO    = 16;
  localparam int unsigned CA_COL_HI    = 2;

  function automatic logic [CA_W-1:0] build_ca(input logic        rw,
                                               input logic        space,
                                               input logic [31:0] addr);
    logic [CA_W-1:0] ca;
    ca                          = '0;
    ca[CA_RW_BIT]               = rw;
    ca[CA_AS_BIT]               = space;
    ca[CA_BURST_BIT]            = 1'b1;
    ca[CA_ROW_HI:CA_ROW_LO]     = addr[31:3];
    ca[CA_COL_HI:0]             = addr[2:0];
    return ca;
  endfunction

  // Zero-length requests move one word; register writes are always single-word.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned burst_max,
                                            input logic        single);
    if (single || len == 0) return 1;
    if (len > burst_max)    return burst_max;
    return len;
  endfunction

endpackage

// File: rtl/hyper_xfer_stm.sv
// Unified HyperRAM transaction sequencer: command/address phase, fixed or
// RWDS-doubled initial latency, then a write or read data burst.
module hyper_xfer_stm
  import hyper_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BURST_MAX  = 16,
  parameter int unsigned LAT_CYCLES = 6,
  parameter int unsigned RD_SKEW    = 2,
  parameter int unsigned LEN_W      = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic              cmd_as,
  input  logic [31:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              csn,
  output logic              oe,
  output logic              oe_clk,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout,
  input  logic              rwds_in,
  output logic              rwds_out,
  output logic              rwds_oe
);

  localparam int unsigned LAT_SPAN = 2 * LAT_CYCLES + RD_SKEW;
  localparam int unsigned CNT_TOP0 = (LAT_SPAN > BURST_MAX) ? LAT_SPAN : BURST_MAX;
  localparam int unsigned CNT_TOP  = (CNT_TOP0 > 3) ? CNT_TOP0 : 3;
  localparam int unsigned CNT_W    = $clog2(CNT_TOP + 1);

  hyper_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_last_q;
  logic [CNT_W-1:0]  lat_last;
  logic [31:0]       ca_lo_q;
  logic [CA_W-1:0]   ca_in;
  logic              rw_q;
  logic              reg_wr_q;
  logic              lat_dbl_q;
  logic [DATA_W-1:0] datain_q;

  always_comb begin
    ca_in = build_ca(cmd_rw, cmd_as, cmd_addr);
  end

  always_comb begin
    lat_last = (lat_dbl_q ? CNT_W'(2 * LAT_CYCLES) : CNT_W'(LAT_CYCLES))
             + (rw_q ? CNT_W'(RD_SKEW) : '0) - CNT_W'(1);
  end

  // Write words pass straight through in the cycle they are offered so that
  // wr_valid/wr_data line up with wr_ready; all other datain values are registered.
  assign datain   = wr_ready ? (wr_valid ? wr_data : '0) : datain_q;
  assign rwds_out = wr_ready & ~wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len_last_q <= '0;
      ca_lo_q    <= '0;
      rw_q       <= 1'b0;
      reg_wr_q   <= 1'b0;
      lat_dbl_q  <= 1'b0;
      datain_q   <= '0;
      cmd_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      csn        <= 1'b1;
      oe         <= 1'b0;
      oe_clk     <= 1'b0;
      rwds_oe    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            rw_q       <= cmd_rw;
            reg_wr_q   <= cmd_as & ~cmd_rw;
            ca_lo_q    <= ca_in[31:0];
            len_last_q <= CNT_W'(clamp_len(32'(cmd_len), BURST_MAX, cmd_as & ~cmd_rw) - 1);
            cmd_ready  <= 1'b0;
            csn        <= 1'b0;
            oe         <= 1'b1;
            oe_clk     <= 1'b1;
            datain_q   <= DATA_W'(ca_in[47:32]);
            cnt        <= '0;
            state      <= ST_CA;
          end
        end

        ST_CA: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '0) begin
            lat_dbl_q <= rwds_in;
          end
          if (cnt == CNT_W'(2)) begin
            cnt      <= '0;
            datain_q <= '0;
            if (reg_wr_q) begin
              state    <= ST_DATA;
              wr_ready <= 1'b1;
              rwds_oe  <= 1'b1;
            end else begin
              state <= ST_LAT;
              oe    <= 1'b0;
            end
          end else if (cnt == '0) begin
            datain_q <= DATA_W'(ca_lo_q[31:16]);
          end else begin
            datain_q <= DATA_W'(ca_lo_q[15:0]);
          end
        end

        ST_LAT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == lat_last) begin
            cnt   <= '0;
            state <= ST_DATA;
            if (!rw_q) begin
              oe       <= 1'b1;
              wr_ready <= 1'b1;
              rwds_oe  <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          cnt <= cnt + CNT_W'(1);
          if (rw_q) begin
            rd_data  <= dataout;
            rd_valid <= 1'b1;
          end
          if (cnt == len_last_q) begin
            cnt      <= '0;
            state    <= ST_DONE;
            csn      <= 1'b1;
            oe       <= 1'b0;
            oe_clk   <= 1'b0;
            rwds_oe  <= 1'b0;
            wr_ready <= 1'b0;
            done     <= 1'b1;
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_xfer_stm.sv
// Randomized bench for hyper_xfer_stm: each transaction is checked against
// a cycle-position model derived from the CA/latency/burst timing rules.
module tb_hyper_xfer_stm;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BURST_MAX  = 16;
  localparam int unsigned LAT_CYCLES = 6;
  localparam int unsigned RD_SKEW    = 2;
  localparam int unsigned LEN_W      = $clog2(BURST_MAX + 1);
  localparam int          MAXC       = 64;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic              cmd_as;
  logic [31:0]       cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              csn;
  logic              oe;
  logic              oe_clk;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              rwds_in;
  logic              rwds_out;
  logic              rwds_oe;

  hyper_xfer_stm #(
    .DATA_W    (DATA_W),
    .BURST_MAX (BURST_MAX),
    .LAT_CYCLES(LAT_CYCLES),
    .RD_SKEW   (RD_SKEW),
    .LEN_W     (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw   (cmd_rw),
    .cmd_as   (cmd_as),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .csn      (csn),
    .oe       (oe),
    .oe_clk   (oe_clk),
    .datain   (datain),
    .dataout  (dataout),
    .rwds_in  (rwds_in),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle record of one transaction, index 1 = first cycle after acceptance.
  logic              r_csn   [MAXC];
  logic              r_oe    [MAXC];
  logic              r_oeclk [MAXC];
  logic              r_rwdsoe[MAXC];
  logic              r_wrr   [MAXC];
  logic              r_wv    [MAXC];
  logic [DATA_W-1:0] r_wd    [MAXC];
  logic [DATA_W-1:0] r_din   [MAXC];
  logic              r_rwo   [MAXC];
  logic [DATA_W-1:0] r_dout  [MAXC];
  logic              r_rdv   [MAXC];
  logic [DATA_W-1:0] r_rdd   [MAXC];
  logic              r_done  [MAXC];

  function automatic int model_len(input int len, input bit rw, input bit sp);
    if (sp && !rw) return 1;
    if (len == 0) return 1;
    if (len > int'(BURST_MAX)) return int'(BURST_MAX);
    return len;
  endfunction

  function automatic logic [47:0] model_ca(input bit rw, input bit sp, input logic [31:0] addr);
    longint unsigned v;
    v = (longint'(rw) << 47) + (longint'(sp) << 46) + (64'd1 << 45)
      + ((longint'(addr) >> 3) << 16) + (longint'(addr) & 64'd7);
    return v[47:0];
  endfunction

  // rst_word >= 0 pulses rst during that data word (0-based) instead of finishing.
  task automatic run_txn(input bit rw, input bit sp, input logic [31:0] addr, input int len,
                         input bit dbl, input int wv_pct, input logic [31:0] wv_low,
                         input int rst_word);
    int          w, lat, skew, n_eff, low, first_data, last_n, done_n, ndone, nwr, nrd;
    int          low_obs, bad, rst_at, j;
    logic [47:0] ca;
    logic [15:0] ca_word;

    lat        = (sp && !rw) ? 0 : (dbl ? 2 * int'(LAT_CYCLES) : int'(LAT_CYCLES));
    skew       = rw ? int'(RD_SKEW) : 0;
    n_eff      = model_len(len, rw, sp);
    low        = 3 + lat + skew + n_eff;
    first_data = 4 + lat + skew;
    rst_at     = (rst_word >= 0) ? first_data + rst_word : -1;
    ca         = model_ca(rw, sp, addr);

    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    check_eq("cmd_ready_idle", cmd_ready, 1);
    if (!cmd_ready) return;

    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_as    = sp;
    cmd_addr  = addr;
    cmd_len   = LEN_W'(len);

    last_n = 0;
    for (int n = 1; n < MAXC; n++) begin
      @(posedge clk); #1;
      j         = n - first_data;
      cmd_valid = (rst_at > 0 && n >= rst_at) ? 1'b0 : 1'($urandom_range(0, 1));
      cmd_rw    = 1'($urandom);
      cmd_as    = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_len   = LEN_W'($urandom);
      rst       = (n == rst_at);
      rwds_in   = (n == 1) ? dbl : 1'($urandom_range(0, 1));
      wr_valid  = (j >= 0 && j < 32 && wv_low[j % 32]) ? 1'b0 : ($urandom_range(0, 99) < wv_pct);
      wr_data   = DATA_W'($urandom);
      dataout   = DATA_W'($urandom);
      @(negedge clk);
      r_csn[n]    = csn;     r_oe[n]   = oe;       r_oeclk[n] = oe_clk;
      r_rwdsoe[n] = rwds_oe; r_wrr[n]  = wr_ready; r_wv[n]    = wr_valid;
      r_wd[n]     = wr_data; r_din[n]  = datain;   r_rwo[n]   = rwds_out;
      r_dout[n]   = dataout; r_rdv[n]  = rd_valid; r_rdd[n]   = rd_data;
      r_done[n]   = done;
      if (rst_at > 0 && n == rst_at + 6) begin last_n = n; break; end
      if (rst_at < 0 && done) begin last_n = n; break; end
    end
    rst = 1'b0;

    if (last_n == 0) begin
      check_eq("done_timeout", 0, 1);
      return;
    end

    ndone = 0;
    done_n = 0;
    for (int n = 1; n <= last_n; n++) if (r_done[n]) begin ndone++; if (done_n == 0) done_n = n; end

    for (int k = 0; k < 3; k++) begin
      ca_word = ca[47 - 16*k -: 16];
      check_eq("ca_word", r_din[k+1], ca_word);
      check_eq("ca_oe", {r_csn[k+1], r_oe[k+1], r_oeclk[k+1]}, 3'b011);
    end

    if (rst_at > 0) begin
      check_eq("rst_csn", r_csn[rst_at+1], 1);
      check_eq("rst_enables", {r_oe[rst_at+1], r_oeclk[rst_at+1], r_rwdsoe[rst_at+1],
                               r_wrr[rst_at+1], r_rdv[rst_at+1], r_rwo[rst_at+1]}, 0);
      check_eq("rst_datain", r_din[rst_at+1], 0);
      check_eq("rst_no_done", ndone, 0);
      return;
    end

    low_obs = 0;
    while (low_obs < last_n && !r_csn[low_obs+1]) low_obs++;
    check_eq("csn_low_len", low_obs, low);
    check_eq("done_cycle", done_n, low + 1);
    check_eq("done_count", ndone, 1);
    check_eq("done_outputs", {r_csn[last_n], r_oe[last_n], r_oeclk[last_n],
                              r_rwdsoe[last_n], r_wrr[last_n]}, 5'b10000);

    bad = 0;
    for (int n = 4; n < first_data; n++)
      if (r_oe[n] || !r_oeclk[n] || r_din[n] != '0 || r_wrr[n] || r_rdv[n]) bad++;
    check_eq("lat_quiet", bad, 0);

    nwr = 0;
    nrd = 0;
    for (int n = 1; n <= last_n; n++) begin
      if (r_wrr[n]) nwr++;
      if (r_rdv[n]) nrd++;
    end
    check_eq("wr_ready_count", nwr, rw ? 0 : n_eff);
    check_eq("rd_valid_count", nrd, rw ? n_eff : 0);

    for (int k = 0; k < n_eff; k++) begin
      if (!rw) begin
        check_eq("wr_strobe", {r_wrr[first_data+k], r_oe[first_data+k], r_rwdsoe[first_data+k]}, 3'b111);
        check_eq("wr_word", r_din[first_data+k], r_wv[first_data+k] ? r_wd[first_data+k] : '0);
        check_eq("wr_mask", r_rwo[first_data+k], !r_wv[first_data+k]);
      end else begin
        check_eq("rd_valid", r_rdv[first_data+k+1], 1);
        check_eq("rd_word", r_rdd[first_data+k+1], r_dout[first_data+k]);
      end
    end

    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("cmd_ready_back", {cmd_ready, done, csn}, 3'b101);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_as    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    dataout   = '0;
    rwds_in   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_csn", csn, 1);
    check_eq("reset_outputs", {cmd_ready, done, rd_valid, wr_ready, oe, oe_clk, rwds_oe, rwds_out}, 0);
    check_eq("reset_datain", datain, 0);
    check_eq("reset_rd_data", rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // memory write, CA words 0x2000/0x0002/0x0000, 13 cycles with csn low
    run_txn(1'b0, 1'b0, 32'h0000_0010, 4, 1'b0, 100, 32'h0, -1);
    // memory read with doubled latency
    run_txn(1'b1, 1'b0, 32'h0012_3456, 3, 1'b1, 100, 32'h0, -1);
    // register write, length forced to one
    run_txn(1'b0, 1'b1, 32'h0000_0801, 5, 1'b0, 100, 32'h0, -1);
    // masked second word
    run_txn(1'b0, 1'b0, 32'hABCD_0007, 4, 1'b0, 100, 32'h2, -1);
    // length boundaries
    run_txn(1'b0, 1'b0, 32'h0000_0100, 0, 1'b1, 100, 32'h0, -1);
    run_txn(1'b1, 1'b0, 32'h0000_0200, 31, 1'b0, 100, 32'h0, -1);
    run_txn(1'b1, 1'b1, 32'h0000_0003, 0, 1'b1, 100, 32'h0, -1);
    // reset during read word 2, then a normal command
    run_txn(1'b1, 1'b0, 32'h0000_0040, 4, 1'b0, 100, 32'h0, 1);
    run_txn(1'b1, 1'b0, 32'h0000_0048, 2, 1'b0, 100, 32'h0, -1);

    for (int t = 0; t < 40; t++)
      run_txn(1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 31)),
              1'($urandom), int'($urandom_range(40, 100)), 32'h0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyper_xfer_stm.md
# hyper_xfer_stm

Unified, parametrised HyperRAM transaction sequencer. It replaces the separate register-read, memory-read and memory-write sequencers with one FSM. It builds the 48-bit command/address (CA) word internally and handles fixed or RWDS-doubled initial latency. It moves variable-length bursts with a valid/ready command port, a byte-masked write stream and a per-word read stream. It sits between the host-side controller logic and the HyperBus PHY (DDR I/O cells driving `datain`, returning `dataout`).

## Interface
Parameters:
- `DATA_W`, 16: PHY word width per `clk` cycle.
- `BURST_MAX`, 16: maximum words per transaction.
- `LAT_CYCLES`, 6: initial latency in `clk` cycles; doubled when `rwds_in` is high during CA.
- `RD_SKEW`, 2: extra cycles from end of latency to first valid `dataout` word.
- `LEN_W`, `$clog2(BURST_MAX+1)`: width of `cmd_len`.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE and not in reset.
- `cmd_rw` input 1: 1 = read, 0 = write.
- `cmd_as` input 1: 1 = register space, 0 = memory.
- `cmd_addr` input 32: word address.
- `cmd_len` input LEN_W: burst length in words.
- `wr_data` input DATA_W: write word.
- `wr_valid` input 1: write word available.
- `wr_ready` output 1: write word consumed this cycle.
- `rd_data` output DATA_W: registered read word.
- `rd_valid` output 1: `rd_data` valid pulse.
- `done` output 1: one-cycle end-of-transaction pulse.
- `csn` output 1: HyperBus chip select, active low.
- `oe` output 1: PHY data output enable.
- `oe_clk` output 1: PHY clock enable.
- `datain` output DATA_W: word to the PHY.
- `dataout` input DATA_W: word from the PHY.
- `rwds_in` input 1: RWDS sampled from the PHY.
- `rwds_out` output 1: write mask (1 = masked).
- `rwds_oe` output 1: RWDS drive enable.

## Operation
- States: IDLE, CA, LAT, DATA, DONE.
- IDLE:
  - `csn`=1.
  - On `cmd_valid && cmd_ready`, latch the command and go to CA.
  - Effective length: `cmd_len`=0 is treated as 1; values above BURST_MAX are clamped to BURST_MAX; a register write is forced to 1.
- CA word layout:
  - bit 47 = `cmd_rw`
  - bit 46 = `cmd_as`
  - bit 45 = 1 (linear burst)
  - bits 44:16 = `cmd_addr[31:3]`
  - bits 15:3 = 0
  - bits 2:0 = `cmd_addr[2:0]`
- CA: 3 cycles. `datain` carries CA[47:32], CA[31:16], CA[15:0] in order; `oe`=1, `oe_clk`=1.
- Latency select: `rwds_in` is sampled in the first CA cycle. 1 gives 2·LAT_CYCLES; 0 gives LAT_CYCLES.
- CA exit:
  - Register write skips LAT and goes straight to DATA.
  - All other commands go to LAT.
- LAT: `oe`=0, `datain`=0, `oe_clk`=1. Counts the selected latency. A read additionally counts RD_SKEW cycles.
- DATA, write:
  - Each cycle: `oe`=1, `rwds_oe`=1, `wr_ready`=1.
  - If `wr_valid`=1: `datain`=`wr_data`, `rwds_out`=0.
  - If `wr_valid`=0: `datain`=0, `rwds_out`=1 (masked word, still counted).
  - Exactly length cycles.
- DATA, read: `oe`=0. For length cycles, `rd_data`<=`dataout` and `rd_valid`=1 on the following cycle.
- DONE, 1 cycle: `csn`=1, `oe`=`oe_clk`=`rwds_oe`=0, `done`=1. Then IDLE.
- Width rules: all counters are sized for 2·LAT_CYCLES+RD_SKEW and BURST_MAX without wrap. Word count is compared against the latched effective length.

## Timing
- Reset values: `csn`=1; all other outputs 0, including `cmd_ready`, `done`, `rd_valid`, `wr_ready` and `datain`.
- Reset mid-transaction: the cycle after `rst` is sampled, `csn`=1, all enables are 0, no `done` pulse is issued, and the state is IDLE.
- `csn` falls the cycle after command acceptance and stays low for 3 + L + len cycles (write) or 3 + L + RD_SKEW + len cycles (read). L = 0 for a register write.
- `done` is asserted the cycle after the last DATA cycle.
- `cmd_ready` returns the cycle after `done`. The minimum command-to-command spacing is therefore one IDLE cycle.
- `rd_valid` lags the sampled `dataout` by 1 cycle. The last `rd_valid` coincides with `done`.
- `cmd_valid` asserted outside IDLE is ignored; it is held off by `cmd_ready`=0.
- `wr_ready` is asserted only in write DATA cycles; a word is consumed only if `wr_valid && wr_ready`.

## Structure
- Shared package `hyper_pkg`:
  - `hyper_state_e` enum.
  - CA field bit positions.
  - `build_ca(rw, as, addr)` function.
  - Length clamp function.
- Single module; no sub-module required. The latency/data counter is shared, reloaded on each state change.

## Test plan
- Memory write, addr 0x0000_0010, len 4, `rwds_in`=0, LAT 6 -> CA words 0x2000/0x0002/0x0000. `csn` low 13 cycles; 4 words on `datain` with `rwds_out`=0; `done` 1 cycle later.
- Memory read, len 3, `rwds_in`=1 during CA -> LAT 12 + skew 2. Three `rd_valid` pulses carrying `dataout` values 0xA1, 0xA2, 0xA3; `csn` low 20 cycles.
- Register write, `cmd_len`=5 -> no LAT; exactly 1 DATA word right after CA; `csn` low 4 cycles.
- Write with `wr_valid` low on word 2 of 4 -> that cycle `datain`=0 and `rwds_out`=1; the burst still ends after 4 words.
- `cmd_len`=0 -> 1 word; `cmd_len`=31 with BURST_MAX 16 -> 16 words.
- `rst` pulsed in read DATA word 2 -> next cycle `csn`=1 and all outputs 0; no `done`; a new command is accepted normally afterward.
